// File: rtl/mem_access_unit_if.sv
// Bus between the datapath, the load/store sequencer and the unified word memory.
// The sequencer uses the slave modport. The master modport is for the datapath or memory side.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] memAdr;
  logic [31:0] writeData;
  logic        memWrite;
  logic [31:0] readData;

  modport slave (
    input  req, we, size, uns, addr, wdata, readData,
    output ready, done, err, rdata, memAdr, writeData, memWrite
  );

  modport master (
    output req, we, size, uns, addr, wdata, readData,
    input  ready, done, err, rdata, memAdr, writeData, memWrite
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer: sign/zero-extended sub-word loads, and read-modify-write
// sub-word stores against a memory that only writes whole aligned words.
//
// state    | meaning
// IDLE     | ready, waiting for a request
// LOAD     | sample memory word, register extended result
// RMW_RD   | sample memory word for a sub-word store
// WRITE    | drive merged or full word with memWrite
// DONE     | completion pulse, err=0
// ERR      | completion pulse, err=1, no memory access made
module mem_access_unit (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_DONE, S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, word_q, rdata_q;
  logic [1:0]  size_q;
  logic        uns_q, we_q;

  logic        accept, misalign;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext, merge;

  assign accept = bus.req && (state_q == S_IDLE);

  always_comb begin
    misalign = 1'b0;
    case (bus.size)
      2'b01:   misalign = bus.addr[0];
      2'b10:   misalign = (bus.addr[1:0] != 2'b00);
      2'b11:   misalign = 1'b1;
      default: misalign = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misalign)               state_d = S_ERR;
          else if (!bus.we)           state_d = S_LOAD;
          else if (bus.size == 2'b10) state_d = S_WRITE;
          else                        state_d = S_RMW_RD;
        end
      end
      S_LOAD:   state_d = S_DONE;
      S_RMW_RD: state_d = S_WRITE;
      S_WRITE:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld_byte  = 8'(bus.readData >> {addr_q[1:0], 3'b000});
    ld_half  = addr_q[1] ? bus.readData[31:16] : bus.readData[15:0];
    load_ext = bus.readData;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_ext = bus.readData;
    endcase
  end

  always_comb begin
    merge = wdata_q;
    case (size_q)
      2'b00: begin
        merge = word_q;
        merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01:   merge = addr_q[1] ? {wdata_q[15:0], word_q[15:0]}
                                 : {word_q[31:16], wdata_q[15:0]};
      default: merge = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        size_q  <= bus.size;
        uns_q   <= bus.uns;
        we_q    <= bus.we;
      end
      if (state_q == S_LOAD) begin
        word_q  <= bus.readData;
        rdata_q <= load_ext;
      end
      if (state_q == S_RMW_RD) word_q <= bus.readData;
    end
  end

  always_comb begin
    bus.ready     = (state_q == S_IDLE);
    bus.done      = (state_q == S_DONE) || (state_q == S_ERR);
    bus.err       = (state_q == S_ERR);
    bus.memWrite  = (state_q == S_WRITE) && we_q;
    bus.writeData = (state_q == S_WRITE) ? merge : 32'h0;
    bus.memAdr    = {addr_q[31:2], 2'b00};
    bus.rdata     = rdata_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver pushes expected completions,
// and a negedge monitor checks done/err/rdata, latency and memory writes.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();
  mem_access_unit dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [0:127];
  assign bus.readData = mem[bus.memAdr[8:2]];
  always @(posedge clk) if (bus.memWrite) mem[bus.memAdr[8:2]] = bus.writeData;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    int          lat;
    logic        e;
    logic [31:0] rd;
    int          nwr;
    int          woff;
    logic [31:0] wd;
  } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int wrcnt   = 0;
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event seen but none expected", name);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.memWrite) begin
        if (q.size() == 0) flag("unexpected_write");
        else begin
          chk("write_cycle", 32'(cyc - q[0].t), 32'(q[0].woff));
          chk("writeData", bus.writeData, q[0].wd);
          wrcnt++;
        end
      end else if (bus.writeData !== 32'h0) begin
        chk("writeData_idle", bus.writeData, 32'h0);
      end
      if (bus.done) begin
        if (q.size() == 0) flag("unexpected_done");
        else begin
          e = q.pop_front();
          chk("done_latency", 32'(cyc - e.t), 32'(e.lat));
          chk("err", {31'b0, bus.err}, {31'b0, e.e});
          chk("rdata", bus.rdata, e.rd);
          chk("write_count", 32'(wrcnt), 32'(e.nwr));
          wrcnt = 0;
        end
      end
    end
  end

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.ready) ok = 1'b1;
    end
    if (!ok) chk("ready_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (q.size() == 0) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      chk("done_timeout", 32'h0, 32'h1);
      q.delete();
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int lat, input logic e, input logic [31:0] rd,
                       input int nwr, input int woff, input logic [31:0] wexp,
                       input int hold);
    exp_t x;
    wait_ready();
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.uns = u;
    bus.addr = a; bus.wdata = wd;
    x.t = cyc; x.lat = lat; x.e = e; x.rd = rd;
    x.nwr = nwr; x.woff = woff; x.wd = wexp;
    q.push_back(x);
    repeat (hold + 1) @(negedge clk);
    bus.req = 1'b0;
    wait_drain();
  endtask

  task automatic ld(input logic [1:0] sz, input logic u, input logic [31:0] a,
                    input logic [31:0] exp, input int hold = 0);
    issue(1'b0, sz, u, a, 32'h0, 2, 1'b0, exp, 0, 0, 32'h0, hold);
    last_rd = exp;
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] wexp);
    if (sz == 2'b10) issue(1'b1, sz, 1'b0, a, wd, 2, 1'b0, last_rd, 1, 1, wexp, 0);
    else             issue(1'b1, sz, 1'b0, a, wd, 3, 1'b0, last_rd, 1, 2, wexp, 0);
  endtask

  task automatic er(input logic w, input logic [1:0] sz, input logic [31:0] a);
    issue(w, sz, 1'b0, a, 32'h5A5A5A5A, 1, 1'b1, last_rd, 0, 0, 32'h0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[7'h40] = 32'hDEADBEEF;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.uns = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, bus.ready}, 32'h1);
    chk("rst_done", {31'b0, bus.done}, 32'h0);
    chk("rst_err", {31'b0, bus.err}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_memAdr", bus.memAdr, 32'h0);
    chk("rst_writeData", bus.writeData, 32'h0);
    chk("rst_memWrite", {31'b0, bus.memWrite}, 32'h0);
    rst = 1'b0;

    ld(2'b00, 1'b0, 32'h103, 32'hFFFFFFDE);
    ld(2'b00, 1'b1, 32'h103, 32'h000000DE);
    ld(2'b01, 1'b0, 32'h102, 32'hFFFFDEAD);
    ld(2'b01, 1'b1, 32'h100, 32'h0000BEEF);
    ld(2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    ld(2'b00, 1'b0, 32'h100, 32'hFFFFFFEF);
    ld(2'b00, 1'b1, 32'h101, 32'h000000BE);
    ld(2'b01, 1'b0, 32'h100, 32'hFFFFBEEF);
    ld(2'b01, 1'b1, 32'h102, 32'h0000DEAD);
    ld(2'b10, 1'b1, 32'h100, 32'hDEADBEEF);

    st(2'b00, 32'h101, 32'h12345677, 32'hDEAD77EF);
    ld(2'b10, 1'b0, 32'h100, 32'hDEAD77EF);

    mem[7'h40] = 32'hDEADBEEF;
    st(2'b01, 32'h102, 32'hAAAA1234, 32'h1234BEEF);
    ld(2'b10, 1'b0, 32'h100, 32'h1234BEEF);
    st(2'b00, 32'h103, 32'h00000080, 32'h8034BEEF);
    ld(2'b00, 1'b0, 32'h103, 32'hFFFFFF80);
    ld(2'b00, 1'b1, 32'h103, 32'h00000080);

    st(2'b10, 32'h104, 32'hCAFEF00D, 32'hCAFEF00D);
    ld(2'b10, 1'b0, 32'h104, 32'hCAFEF00D);

    er(1'b0, 2'b10, 32'h102);
    er(1'b1, 2'b01, 32'h101);
    er(1'b0, 2'b11, 32'h100);
    er(1'b1, 2'b11, 32'h104);
    er(1'b1, 2'b10, 32'h106);
    chk("mem100_after_err", mem[7'h40], 32'h8034BEEF);
    chk("mem104_after_err", mem[7'h41], 32'hCAFEF00D);

    ld(2'b10, 1'b0, 32'h100, 32'h8034BEEF, 2);

    // Reset in the middle of a read-modify-write: no write may reach memory.
    wait_ready();
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.uns = 1'b0;
    bus.addr = 32'h100; bus.wdata = 32'h00000055;
    @(negedge clk);
    bus.req = 1'b0;
    chk("rmw_rd_busy", {31'b0, bus.ready}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", {31'b0, bus.ready}, 32'h1);
    chk("rst_mid_memWrite", {31'b0, bus.memWrite}, 32'h0);
    chk("rst_mid_rdata", bus.rdata, 32'h0);
    chk("rst_mid_memAdr", bus.memAdr, 32'h0);
    rst = 1'b0;
    last_rd = 32'h0;
    repeat (4) @(negedge clk);
    chk("mem100_after_rst", mem[7'h40], 32'h8034BEEF);

    ld(2'b10, 1'b0, 32'h100, 32'h8034BEEF);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the multi-cycle RISC-V datapath and the unified word-wide instruction/data memory. It accepts one byte, halfword or word request at a time. Loads are returned sign- or zero-extended. Sub-word stores are performed as read-modify-write, because the memory only writes whole aligned words.

## Interface
- None. Address and data widths are fixed at 32 bits.

- clk  in  1  Single system clock. All state updates on its rising edge.
- rst  in  1  Reset, synchronous and active-high.
- req  in  1  Request strobe. Sampled only while ready=1.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- uns  in  1  Zero-extend loads when 1 (lbu/lhu). Ignored for stores and word loads.
- addr  in  32  Byte address.
- wdata  in  32  Store data, right-justified.
- ready  out  1  High only in IDLE.
- done  out  1  One-cycle completion pulse.
- err  out  1  Valid with done. 1 = misaligned or illegal size; no memory access was made.
- rdata  out  32  Extended load result. Held until the next load completes.
- memAdr  out  32  Word address to memory, {addr_q[31:2],2'b00}.
- writeData  out  32  Word to memory.
- memWrite  out  1  Memory write enable.
- readData  in  32  Memory read word (combinational from memAdr).

## Operation
- On accept (req & ready), latch addr, wdata, size, uns and we into addr_q, wdata_q, size_q, uns_q and we_q.
- States and transitions:
  - IDLE -> ERR on accept if size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
  - IDLE -> LOAD on an accepted load.
  - IDLE -> WRITE on an accepted word store.
  - IDLE -> RMW_RD on an accepted byte or half store.
  - LOAD -> DONE. RMW_RD -> WRITE. WRITE -> DONE.
  - DONE -> IDLE. ERR -> IDLE.
- LOAD:
  - Capture readData into word_q.
  - In the same cycle, compute rdata and register it at the clock edge.
- Load extraction is little-endian (lane 0 = bits [7:0]):
  - Byte: lane addr_q[1:0].
  - Half: bits [16*addr_q[1]+15 : 16*addr_q[1]].
  - Extension: sign-extend when uns_q=0, zero-extend otherwise.
- RMW_RD: capture readData into word_q.
- WRITE drives memWrite=1 and writeData:
  - Word store: wdata_q.
  - Byte store: word_q with lane addr_q[1:0] replaced by wdata_q[7:0].
  - Half store: word_q with half addr_q[1] replaced by wdata_q[15:0].
- DONE: done=1, err=0.
- ERR: done=1, err=1, memWrite=0, rdata unchanged.
- memWrite is 1 only in WRITE. writeData is 0 in all other states.
- req while ready=0 is ignored. The request is not queued.

## Timing
- Reset values: state=IDLE, ready=1, done=0, err=0, rdata=0, memAdr=0, writeData=0, memWrite=0. All latched registers are 0.
- Accept at cycle T (accept edge at the end of T). Completion:
  - Load: LOAD in T+1, done in T+2.
  - Word store: WRITE in T+1, done in T+2.
  - Sub-word store: RMW_RD in T+1, WRITE in T+2, done in T+3.
  - Error: done/err in T+1.
- ready is low from T+1 through the done cycle and returns high the cycle after done. The next request can be accepted 1 cycle after done.
- memAdr is stable from T+1 until the next accept.
- rst=1 in any state: next state is IDLE and all outputs return to reset values. memWrite is low the cycle after rst is sampled. An interrupted RMW therefore never writes, and memory keeps its prior word.
- Back-to-back: a request asserted in the same cycle as done is ignored, because ready=0.

## Test plan
- Preload word 0x100=0xDEADBEEF.
  - lb 0x103 -> rdata=0xFFFFFFDE.
  - lbu 0x103 -> 0x000000DE.
  - Each completes with done at T+2, err=0.
- lh 0x102 -> 0xFFFFDEAD. lhu 0x100 -> 0x0000BEEF. lw 0x100 -> 0xDEADBEEF.
- sb 0x101 with wdata=0x12345677:
  - memWrite high only at T+2, writeData=0xDEAD77EF.
  - done at T+3. A following lw 0x100 returns 0xDEAD77EF.
- sh 0x102 with wdata=0xAAAA1234 -> word 0x1234BEEF.
- sw 0x104 with wdata=0xCAFEF00D -> memWrite at T+1, done at T+2.
- lw 0x102, sh 0x101 and size=11 each give done+err at T+1. memWrite stays 0 and memory is unchanged.
- Assert rst during RMW_RD of sb 0x100:
  - Next cycle: IDLE, ready=1.
  - memWrite never asserts and word 0x100 is unchanged.
- Hold req high continuously through a load: exactly one access and one done pulse per accept. No request is accepted while busy.
